// File: rtl/val2_shifter_pipe.sv
// Two-stage operand-2 generator: S1 decodes the shifter operand, S2 registers val2/carry_out.
// Define VAL2_CARRY_EN to compute the shifter carry; otherwise carry_out is the registered carry_in.
module val2_shifter_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [7:0]        rs_val,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              mem_instr,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam int          AW = $clog2(DATA_W);
  localparam logic [8:0]  W9 = 9'(DATA_W);

  typedef enum logic [1:0] {FORM_MEM, FORM_IMM, FORM_SHIFT, FORM_RRX} form_e;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shtype_e;

  // Handshake: a beat moves whenever valid && ready are both high at a rising edge.
  // flush squashes both stages and blocks acceptance in the same cycle.
  logic              s1_valid_q, s1_valid_d;
  form_e             s1_form_q,  s1_form_d;
  shtype_e           s1_type_q,  s1_type_d;
  logic [8:0]        s1_amt_q,   s1_amt_d;
  logic [DATA_W-1:0] s1_rm_q,    s1_rm_d;
  logic              s1_cin_q,   s1_cin_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] val2_q,     val2_d;
  logic              carry_q,    carry_d;

  form_e             dec_form;
  shtype_e           dec_type;
  logic [8:0]        dec_amt;
  logic [DATA_W-1:0] dec_rm;
  logic [DATA_W-1:0] sh_val;
  logic              sh_carry;
  logic              s2_adv;
  logic              accept;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !flush && (!s1_valid_q || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

  // Every form is normalised to a register-style shift, so immediate #0 cases become amounts.
  always_comb begin
    dec_form = FORM_SHIFT;
    dec_type = shtype_e'(shift_operand[6:5]);
    dec_amt  = {1'b0, rs_val};
    dec_rm   = rm_val;
    if (mem_instr) begin
      dec_form = FORM_MEM;
      dec_type = SH_LSL;
      dec_amt  = '0;
      dec_rm   = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      dec_form = FORM_IMM;
      dec_type = SH_ROR;
      dec_amt  = {4'b0000, shift_operand[11:8], 1'b0};
      dec_rm   = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    end else if (!shift_operand[4]) begin
      dec_amt = {4'b0000, shift_operand[11:7]};
      if (shift_operand[11:7] == 5'd0) begin
        case (dec_type)
          SH_LSR, SH_ASR: dec_amt  = W9;
          SH_ROR:         dec_form = FORM_RRX;
          default:        dec_form = FORM_SHIFT;
        endcase
      end
    end
  end

  always_comb begin
    sh_val   = s1_rm_q;
    sh_carry = s1_cin_q;
    case (s1_form_q)
      FORM_RRX: begin
        sh_val = {s1_cin_q, s1_rm_q[DATA_W-1:1]};
`ifdef VAL2_CARRY_EN
        sh_carry = s1_rm_q[0];
`endif
      end
      FORM_MEM: sh_val = s1_rm_q;
      default: begin
        if (s1_amt_q != '0) begin
          case (s1_type_q)
            SH_LSL: sh_val = s1_rm_q << s1_amt_q;
            SH_LSR: sh_val = s1_rm_q >> s1_amt_q;
            SH_ASR: sh_val = $signed(s1_rm_q) >>> s1_amt_q;
            default: sh_val = (s1_rm_q >> s1_amt_q[AW-1:0]) |
                              (s1_rm_q << (DATA_W - int'(s1_amt_q[AW-1:0])));
          endcase
`ifdef VAL2_CARRY_EN
          // A one-bit guard beside rm captures the last bit shifted out for any amount.
          case (s1_type_q)
            SH_LSL: sh_carry = |(({1'b0, s1_rm_q} << s1_amt_q) >> DATA_W);
            SH_LSR: sh_carry = |(({s1_rm_q, 1'b0} >> s1_amt_q) & (DATA_W+1)'(1));
            SH_ASR: sh_carry = (s1_amt_q >= W9) ? s1_rm_q[DATA_W-1]
                               : |(({s1_rm_q, 1'b0} >> s1_amt_q) & (DATA_W+1)'(1));
            default: sh_carry = sh_val[DATA_W-1];
          endcase
`endif
        end
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_form_d  = s1_form_q;
    s1_type_d  = s1_type_q;
    s1_amt_d   = s1_amt_q;
    s1_rm_d    = s1_rm_q;
    s1_cin_d   = s1_cin_q;
    s2_valid_d = s2_valid_q;
    val2_d     = val2_q;
    carry_d    = carry_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          val2_d  = sh_val;
          carry_d = sh_carry;
        end
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_form_d  = dec_form;
        s1_type_d  = dec_type;
        s1_amt_d   = dec_amt;
        s1_rm_d    = dec_rm;
        s1_cin_d   = carry_in;
      end else if (s2_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_form_q  <= FORM_MEM;
      s1_type_q  <= SH_LSL;
      s1_amt_q   <= '0;
      s1_rm_q    <= '0;
      s1_cin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      val2_q     <= '0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_form_q  <= s1_form_d;
      s1_type_q  <= s1_type_d;
      s1_amt_q   <= s1_amt_d;
      s1_rm_q    <= s1_rm_d;
      s1_cin_q   <= s1_cin_d;
      s2_valid_q <= s2_valid_d;
      val2_q     <= val2_d;
      carry_q    <= carry_d;
    end
  end

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Directed bench for val2_shifter_pipe: reference model feeds an expected queue checked at handoff.
module tb_val2_shifter_pipe;
  localparam int W  = 32;
  localparam int CW = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] rm_val = '0;
  logic [7:0]   rs_val = '0;
  logic [11:0]  shift_operand = '0;
  logic         imm = 1'b0;
  logic         mem_instr = 1'b0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] val2;
  logic         carry_out;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  int           occ = 0;
  logic         prev_stall = 1'b0;
  logic         prev_flush = 1'b0;
  logic [W:0]   prev_out = '0;

  always #5 clk = ~clk;

  val2_shifter_pipe #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rm_val(rm_val), .rs_val(rs_val), .shift_operand(shift_operand), .imm(imm),
    .mem_instr(mem_instr), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .val2(val2), .carry_out(carry_out)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[(i + k) % W];
    return r;
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] rm, input logic [7:0] rs,
                                       input logic [11:0] so, input logic im,
                                       input logic mem, input logic cin);
    logic [W-1:0] r;
    logic         c;
    int           n;
    int           k;
    r = rm;
    c = cin;
    if (mem) begin
      r = {{(W-12){so[11]}}, so};
    end else if (im) begin
      n = 2 * int'(so[11:8]);
      r = rotr({24'h0, so[7:0]}, n);
      if (n != 0) c = r[W-1];
    end else if (!so[4]) begin
      n = int'(so[11:7]);
      case (so[6:5])
        2'b00: if (n != 0) begin r = rm << n; c = rm[W-n]; end
        2'b01: begin
          if (n == 0) n = W;
          r = (n == W) ? '0 : rm >> n;
          c = rm[n-1];
        end
        2'b10: begin
          if (n == 0) n = W;
          r = (n == W) ? {W{rm[W-1]}} : $signed(rm) >>> n;
          c = rm[n-1];
        end
        default: begin
          if (n == 0) begin r = {cin, rm[W-1:1]}; c = rm[0]; end
          else begin r = rotr(rm, n); c = rm[n-1]; end
        end
      endcase
    end else begin
      n = int'(rs);
      if (n != 0) begin
        case (so[6:5])
          2'b00: begin
            if (n < W) begin r = rm << n; c = rm[W-n]; end
            else if (n == W) begin r = '0; c = rm[0]; end
            else begin r = '0; c = 1'b0; end
          end
          2'b01: begin
            if (n < W) begin r = rm >> n; c = rm[n-1]; end
            else if (n == W) begin r = '0; c = rm[W-1]; end
            else begin r = '0; c = 1'b0; end
          end
          2'b10: begin
            if (n < W) begin r = $signed(rm) >>> n; c = rm[n-1]; end
            else begin r = {W{rm[W-1]}}; c = rm[W-1]; end
          end
          default: begin
            k = n % W;
            if (k == 0) begin r = rm; c = rm[W-1]; end
            else begin r = rotr(rm, k); c = rm[k-1]; end
          end
        endcase
      end
    end
`ifndef VAL2_CARRY_EN
    c = cin;
`endif
    return {c, r};
  endfunction

  // Monitor: handshake occupancy, stall stability and in-order result checking.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [W:0] e;
    if (!rst) begin
      occ = 0;
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      exp_rdy = !flush && (occ < 2 || out_ready);
      chk("in_ready", CW'(in_ready), CW'(exp_rdy));
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", CW'(out_valid), CW'(1));
        chk("stall_hold", {carry_out, val2}, prev_out);
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL unexpected_result observed=%h expected=none", {carry_out, val2});
        end else begin
          e = exp_q.pop_front();
          chk("result", {carry_out, val2}, e);
        end
      end
      if (flush) occ = 0;
      else occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_out   = {carry_out, val2};
    end
  end

  task automatic send(input logic [W-1:0] rm, input logic [7:0] rs, input logic [11:0] so,
                      input logic im, input logic mem, input logic cin);
    int t;
    t = 0;
    in_valid = 1'b1;
    rm_val = rm;
    rs_val = rs;
    shift_operand = so;
    imm = im;
    mem_instr = mem;
    carry_in = cin;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $error("FAIL accept_timeout observed=in_ready 0 expected=1");
    end else begin
      exp_q.push_back(model(rm, rs, so, im, mem, cin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with no traffic
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_val2", CW'(val2), CW'(0));
    chk("rst_carry", CW'(carry_out), CW'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", CW'(in_ready), CW'(1));
    @(posedge clk);
    #1;

    // Directed forms and boundaries
    send(32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0001, 8'd32, 12'h010, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0001, 8'd33, 12'h010, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0001, 8'd64, 12'h070, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0003, 8'd0, 12'h060, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 8'd0, 12'h020, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0000, 8'd40, 12'h050, 1'b0, 1'b0, 1'b0);
    send(32'h0000_00F8, 8'd4, 12'h030, 1'b0, 1'b0, 1'b0);
    send(32'hF000_000F, 8'd0, 12'h200, 1'b0, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 8'd0, 12'h040, 1'b0, 1'b0, 1'b1);
    send(32'h1234_5678, 8'd0, 12'h460, 1'b0, 1'b0, 1'b0);
    send(32'hDEAD_BEEF, 8'd0, 12'h030, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0000, 8'd0, 12'h0F1, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-to-back stream with a three-cycle consumer stall
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      send($urandom, 8'($urandom_range(0, 80)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom));
    end
    drain();
    out_ready = 1'b1;

    // Asynchronous reset with beats in flight
    out_ready = 1'b0;
    send(32'hAAAA_5555, 8'd1, 12'h010, 1'b0, 1'b0, 1'b0);
    send(32'h5555_AAAA, 8'd2, 12'h030, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("async_rst_out_valid", CW'(out_valid), CW'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;

    // Flush with two beats in flight, then a memory-form beat
    out_ready = 1'b0;
    send(32'h1111_1111, 8'd3, 12'h010, 1'b0, 1'b0, 1'b0);
    send(32'h2222_2222, 8'd5, 12'h030, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_out_valid", CW'(out_valid), CW'(0));
    out_ready = 1'b1;
    send(32'h0, 8'd0, 12'h800, 1'b0, 1'b1, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
